// File: rtl/fifo256x1_pkg.sv
// rtl/fifo256x1_pkg.sv - shared constants and state type for the 256x1 FIFO controller
package fifo256x1_pkg;

    localparam int FIFO_DEPTH = 256;
    localparam int FIFO_AW    = 8;
    localparam int FIFO_CW    = 9;

    localparam logic [FIFO_CW-1:0] PROG_FULL_MIN  = 9'd1;
    localparam logic [FIFO_CW-1:0] PROG_FULL_MAX  = 9'd256;
    localparam logic [FIFO_CW-1:0] PROG_EMPTY_MAX = 9'd255;

    typedef struct packed {
        logic [FIFO_AW-1:0] wr_ptr;
        logic [FIFO_AW-1:0] rd_ptr;
        logic [FIFO_CW-1:0] count;
        logic               dout;
        logic               valid;
        logic               full;
        logic               empty;
        logic               prog_full;
        logic               prog_empty;
        logic               overflow;
        logic               underflow;
    } fifo_state_t;

    localparam fifo_state_t FIFO_STATE_RST = '{
        wr_ptr:     '0,
        rd_ptr:     '0,
        count:      '0,
        dout:       1'b0,
        valid:      1'b0,
        full:       1'b0,
        empty:      1'b1,
        prog_full:  1'b0,
        prog_empty: 1'b1,
        overflow:   1'b0,
        underflow:  1'b0
    };

    function automatic logic [FIFO_CW-1:0] clamp_thresh(
        input logic [FIFO_CW-1:0] val,
        input logic [FIFO_CW-1:0] lo,
        input logic [FIFO_CW-1:0] hi
    );
        if (val < lo)
            return lo;
        else if (val > hi)
            return hi;
        else
            return val;
    endfunction

endpackage

// File: rtl/fifo256x1_ctrl.sv
// rtl/fifo256x1_ctrl.sv - pointer, count and flag control for a RAM256X1D-backed 256x1 FIFO
module fifo256x1_ctrl
    import fifo256x1_pkg::*;
#(
    parameter logic                IS_CLK_INVERTED   = 1'b0,
    parameter logic [FIFO_CW-1:0]  PROG_FULL_THRESH  = 9'd240,
    parameter logic [FIFO_CW-1:0]  PROG_EMPTY_THRESH = 9'd16
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               WR_EN,
    input  logic               DIN,
    input  logic               RD_EN,
    output logic               DOUT,
    output logic               VALID,
    output logic               FULL,
    output logic               EMPTY,
    output logic               PROG_FULL,
    output logic               PROG_EMPTY,
    output logic               OVERFLOW,
    output logic               UNDERFLOW,
    output logic [FIFO_CW-1:0] COUNT,
    output logic               RAM_WE,
    output logic [FIFO_AW-1:0] RAM_A,
    output logic [FIFO_AW-1:0] RAM_DPRA,
    output logic               RAM_D,
    input  logic               RAM_DPO
);

    // Out-of-range thresholds are pinned to the nearest legal value.
    localparam logic [FIFO_CW-1:0] PF_TH = clamp_thresh(PROG_FULL_THRESH, PROG_FULL_MIN, PROG_FULL_MAX);
    localparam logic [FIFO_CW-1:0] PE_TH = clamp_thresh(PROG_EMPTY_THRESH, 9'd0, PROG_EMPTY_MAX);

    fifo_state_t st = FIFO_STATE_RST;
    fifo_state_t st_nxt;
    logic        wa;
    logic        ra;

    assign wa = WR_EN & ~st.full;
    assign ra = RD_EN & ~st.empty;

    assign RAM_WE   = wa;
    assign RAM_D    = DIN;
    assign RAM_A    = st.wr_ptr;
    assign RAM_DPRA = st.rd_ptr;

    always_comb begin
        st_nxt           = st;
        st_nxt.wr_ptr    = st.wr_ptr + FIFO_AW'(wa);
        st_nxt.rd_ptr    = st.rd_ptr + FIFO_AW'(ra);
        st_nxt.valid     = ra;
        st_nxt.overflow  = WR_EN & st.full;
        st_nxt.underflow = RD_EN & st.empty;
        if (ra)
            st_nxt.dout = RAM_DPO;
        case ({wa, ra})
            2'b10:   st_nxt.count = st.count + 9'd1;
            2'b01:   st_nxt.count = st.count - 9'd1;
            default: st_nxt.count = st.count;
        endcase
        st_nxt.full       = (st_nxt.count == FIFO_CW'(FIFO_DEPTH));
        st_nxt.empty      = (st_nxt.count == '0);
        st_nxt.prog_full  = (st_nxt.count >= PF_TH);
        st_nxt.prog_empty = (st_nxt.count <= PE_TH);
    end

    // The RAM's WCLK inversion must match, so the commit edge is chosen here at elaboration.
    generate
        if (IS_CLK_INVERTED) begin : g_neg
            always_ff @(negedge CLK) begin
                if (!RSTN)
                    st <= FIFO_STATE_RST;
                else
                    st <= st_nxt;
            end
        end else begin : g_pos
            always_ff @(posedge CLK) begin
                if (!RSTN)
                    st <= FIFO_STATE_RST;
                else
                    st <= st_nxt;
            end
        end
    endgenerate

    assign DOUT       = st.dout;
    assign VALID      = st.valid;
    assign FULL       = st.full;
    assign EMPTY      = st.empty;
    assign PROG_FULL  = st.prog_full;
    assign PROG_EMPTY = st.prog_empty;
    assign OVERFLOW   = st.overflow;
    assign UNDERFLOW  = st.underflow;
    assign COUNT      = st.count;

endmodule
